// File: rtl/mandel_job_sched.sv
// Mandelbrot frame scheduler: raster-walks the screen deriving c incrementally,
// hands one pixel job per handshake to NCORE engines round-robin, and funnels
// engine results into the single framebuffer write port.
module mandel_job_sched #(
  parameter int NCORE = 2,
  parameter int HRES  = 320,
  parameter int VRES  = 240,
  parameter int FW    = 16,
  parameter int IW    = 8,
  parameter int AW    = 17
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   start,
  input  logic signed [FW-1:0]   re0,
  input  logic signed [FW-1:0]   im0,
  input  logic signed [FW-1:0]   step,
  output logic                   busy,
  output logic                   done,
  output logic [NCORE-1:0]       job_valid,
  input  logic [NCORE-1:0]       job_ready,
  output logic signed [FW-1:0]   job_cre,
  output logic signed [FW-1:0]   job_cim,
  input  logic [NCORE-1:0]       res_valid,
  output logic [NCORE-1:0]       res_ready,
  input  logic [NCORE*IW-1:0]    res_iter,
  output logic                   fb_we,
  output logic [AW-1:0]          fb_addr,
  output logic [IW-1:0]          fb_data
);

  localparam int PW = (NCORE > 1) ? $clog2(NCORE) : 1;
  localparam int XW = (HRES > 1) ? $clog2(HRES) : 1;
  localparam int YW = (VRES > 1) ? $clog2(VRES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DISPATCH, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic signed [FW-1:0]  cur_re_q, cur_re_d, cur_im_q, cur_im_d;
  logic signed [FW-1:0]  row_re_q, row_re_d, step_q, step_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [NCORE-1:0]      pending_q, pending_d, job_valid_q, job_valid_d;
  logic [PW-1:0]         disp_ptr_q, disp_ptr_d, res_ptr_q, res_ptr_d;
  logic                  busy_q, busy_d, done_q, done_d, abort_q, abort_d;
  logic                  fb_we_q, fb_we_d;
  logic [AW-1:0]         fb_addr_q, fb_addr_d;
  logic [IW-1:0]         fb_data_q, fb_data_d;
  logic [AW-1:0]         tag_q [NCORE];

  logic [NCORE-1:0]      hs, gnt;
  logic [PW-1:0]         hs_idx, gnt_idx;
  logic                  last_pix;

  // First requester at or after ptr, wrapping; returns one-hot or zero.
  function automatic logic [NCORE-1:0] rr_pick(input logic [NCORE-1:0] req,
                                               input logic [PW-1:0] ptr);
    logic [NCORE-1:0] pick;
    int idx;
    pick = '0;
    for (int i = NCORE - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NCORE) idx = idx - NCORE;
      if (req[idx]) begin
        pick = '0;
        pick[idx] = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [PW-1:0] oh_idx(input logic [NCORE-1:0] oh);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < NCORE; i++) if (oh[i]) r = PW'(i);
    return r;
  endfunction

  function automatic logic [PW-1:0] rr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(NCORE - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign hs       = job_valid_q & job_ready;
  assign hs_idx   = oh_idx(hs);
  assign gnt      = rr_pick(res_valid & pending_q, res_ptr_q);
  assign gnt_idx  = oh_idx(gnt);
  assign last_pix = (x_q == XW'(HRES - 1)) && (y_q == YW'(VRES - 1));

  // Next-state logic: FSM, pixel walker, dispatch offer and result arbitration.
  always_comb begin
    // NOTE: every _d gets a default before any branch so no path leaves it unassigned (no latch).
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    cur_re_d    = cur_re_q;
    cur_im_d    = cur_im_q;
    row_re_d    = row_re_q;
    step_d      = step_q;
    addr_d      = addr_q;
    job_valid_d = job_valid_q;
    disp_ptr_d  = disp_ptr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    abort_d     = abort_q;
    fb_we_d     = 1'b0;
    fb_addr_d   = fb_addr_q;
    fb_data_d   = fb_data_q;
    res_ptr_d   = res_ptr_q;
    // A grant and a dispatch never hit the same engine: hs needs pending=0, gnt needs pending=1.
    pending_d   = (pending_q & ~gnt) | hs;

    if (|gnt) begin
      res_ptr_d = rr_next(gnt_idx);
      fb_we_d   = 1'b1;
      fb_addr_d = tag_q[gnt_idx];
      fb_data_d = res_iter[int'(gnt_idx)*IW +: IW];
    end

    unique case (state_q)
      S_IDLE: begin
        if (start && enable) begin
          state_d = S_LOAD;
          busy_d  = 1'b1;
        end
      end
      S_LOAD: begin
        cur_re_d = re0;
        cur_im_d = im0;
        row_re_d = re0;
        step_d   = step;
        x_d      = '0;
        y_d      = '0;
        addr_d   = '0;
        abort_d  = 1'b0;
        state_d  = S_DISPATCH;
      end
      S_DISPATCH: begin
        if (|hs) begin
          disp_ptr_d = rr_next(hs_idx);
          addr_d     = addr_q + 1'b1;
          if (x_q != XW'(HRES - 1)) begin
            x_d      = x_q + 1'b1;
            cur_re_d = cur_re_q + step_q;
          end else begin
            x_d      = '0;
            y_d      = y_q + 1'b1;
            cur_re_d = row_re_q;
            cur_im_d = cur_im_q - step_q;
          end
        end
        if ((|hs) && last_pix) begin
          job_valid_d = '0;
          state_d     = S_DRAIN;
        end else if (!enable) begin
          job_valid_d = '0;
          abort_d     = 1'b1;
          state_d     = S_DRAIN;
        end else if ((|hs) || (job_valid_q == '0)) begin
          // Pre-grant pending is used, so an engine freed this cycle waits one cycle.
          job_valid_d = rr_pick(job_ready & ~(pending_q | hs), disp_ptr_d);
        end
      end
      S_DRAIN: begin
        if (pending_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = !abort_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge ck) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst) begin
      state_q     <= S_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      cur_re_q    <= '0;
      cur_im_q    <= '0;
      row_re_q    <= '0;
      step_q      <= '0;
      addr_q      <= '0;
      pending_q   <= '0;
      job_valid_q <= '0;
      disp_ptr_q  <= '0;
      res_ptr_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      fb_we_q     <= 1'b0;
      fb_addr_q   <= '0;
      fb_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      cur_re_q    <= cur_re_d;
      cur_im_q    <= cur_im_d;
      row_re_q    <= row_re_d;
      step_q      <= step_d;
      addr_q      <= addr_d;
      pending_q   <= pending_d;
      job_valid_q <= job_valid_d;
      disp_ptr_q  <= disp_ptr_d;
      res_ptr_q   <= res_ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      fb_we_q     <= fb_we_d;
      fb_addr_q   <= fb_addr_d;
      fb_data_q   <= fb_data_d;
    end
  end

  // Per-engine address tag captured on each dispatch handshake.
  always_ff @(posedge ck) begin
    // NOTE: tags are not reset; a tag is only read while its pending bit is set, which reset clears.
    if (rst && (|hs)) tag_q[hs_idx] <= addr_q;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign job_valid = job_valid_q;
  assign job_cre   = cur_re_q;
  assign job_cim   = cur_im_q;
  assign res_ready = gnt;
  assign fb_we     = fb_we_q;
  assign fb_addr   = fb_addr_q;
  assign fb_data   = fb_data_q;

endmodule

// File: tb/tb_mandel_job_sched.sv
// Directed bench for mandel_job_sched on a 4x2 screen with two behavioural engines.
module tb_mandel_job_sched;

  localparam int NCORE = 2;
  localparam int HRES  = 4;
  localparam int VRES  = 2;
  localparam int FW    = 16;
  localparam int IW    = 8;
  localparam int AW    = 4;

  logic                  ck = 1'b0;
  logic                  rst;
  logic                  en_q;
  logic                  kill;
  logic                  enable;
  logic                  start;
  logic signed [FW-1:0]  re0, im0, stp;
  logic                  busy, done;
  logic [NCORE-1:0]      job_valid, job_ready;
  logic signed [FW-1:0]  job_cre, job_cim;
  logic [NCORE-1:0]      res_valid, res_ready;
  logic [NCORE*IW-1:0]   res_iter;
  logic                  fb_we;
  logic [AW-1:0]         fb_addr;
  logic [IW-1:0]         fb_data;

  assign enable = en_q & ~kill;

  mandel_job_sched #(.NCORE(NCORE), .HRES(HRES), .VRES(VRES), .FW(FW), .IW(IW), .AW(AW)) dut (
    .ck(ck), .rst(rst), .enable(enable), .start(start),
    .re0(re0), .im0(im0), .step(stp),
    .busy(busy), .done(done),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_cre(job_cre), .job_cim(job_cim),
    .res_valid(res_valid), .res_ready(res_ready), .res_iter(res_iter),
    .fb_we(fb_we), .fb_addr(fb_addr), .fb_data(fb_data)
  );

  always #5 ck = ~ck;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine model and logging state
  int   eng_busy [NCORE];
  int   eng_cnt  [NCORE];
  int   eng_iter [NCORE];
  int   pend_iter[NCORE];
  logic hold_res = 1'b0;
  int   bp_arm = 0, bp_left = 0, bp_d = 0;
  logic [NCORE-1:0] bp_v;
  int   bp_re = 0, bp_im = 0;
  int   kill_at = 0;
  logic [NCORE-1:0] hs_s, gnt_s;
  int   cyc = 0, disp_cnt = 0, wr_cnt = 0, done_cnt = 0, frame_base = 0, oh_bad = 0;
  int   d_core[64], d_cre[64], d_cim[64];
  int   w_addr[64], w_data[64], w_cyc[64];

  // Engines: accept when idle, answer 3 cycles later with iter = raster index of the job.
  initial begin
    job_ready = '0;
    res_valid = '0;
    res_iter  = '0;
    hs_s      = '0;
    gnt_s     = '0;
    kill      = 1'b0;
    bp_v      = '0;
    for (int k = 0; k < NCORE; k++) begin
      eng_busy[k] = 0; eng_cnt[k] = 0; eng_iter[k] = 0; pend_iter[k] = 0;
    end
    forever begin
      @(negedge ck);
      cyc++;
      for (int k = 0; k < NCORE; k++) begin
        if (!rst) begin
          eng_busy[k] = 0;
          eng_cnt[k]  = 0;
        end else begin
          if (gnt_s[k]) eng_busy[k] = 0;
          if (hs_s[k]) begin
            eng_busy[k] = 1;
            eng_cnt[k]  = 3;
            eng_iter[k] = pend_iter[k];
          end else if (eng_busy[k] != 0 && eng_cnt[k] > 0) begin
            eng_cnt[k]--;
          end
        end
      end
      if (bp_arm != 0 && (disp_cnt - frame_base) >= 3 && job_valid != '0) begin
        bp_arm  = 0;
        bp_left = 5;
        bp_v    = job_valid;
        bp_re   = int'(job_cre);
        bp_im   = int'(job_cim);
        bp_d    = disp_cnt;
      end
      for (int k = 0; k < NCORE; k++) begin
        job_ready[k] = (bp_left > 0) ? 1'b0 : (eng_busy[k] == 0);
        res_valid[k] = (eng_busy[k] != 0) && (eng_cnt[k] == 0) && !hold_res;
        res_iter[k*IW +: IW] = IW'(eng_iter[k]);
      end
      #3;
      if (bp_left > 0) begin
        check("bp_job_valid", job_valid, bp_v);
        check("bp_job_cre", int'(job_cre), bp_re);
        check("bp_job_cim", int'(job_cim), bp_im);
        check("bp_no_dispatch", disp_cnt, bp_d);
        bp_left--;
      end
      hs_s  = rst ? (job_valid & job_ready) : '0;
      gnt_s = rst ? res_ready : '0;
      if (!$onehot0(res_ready)) oh_bad++;
      if (!$onehot0(job_valid)) oh_bad++;
      for (int k = 0; k < NCORE; k++) begin
        if (hs_s[k] && disp_cnt < 64) begin
          d_core[disp_cnt] = k;
          d_cre[disp_cnt]  = int'(job_cre);
          d_cim[disp_cnt]  = int'(job_cim);
          pend_iter[k]     = disp_cnt - frame_base;
          disp_cnt++;
        end
      end
      if (fb_we && wr_cnt < 64) begin
        w_addr[wr_cnt] = int'(fb_addr);
        w_data[wr_cnt] = int'(fb_data);
        w_cyc[wr_cnt]  = cyc;
        wr_cnt++;
      end
      if (done) done_cnt++;
      kill = (kill_at > 0) && (kill || (rst && (disp_cnt - frame_base) >= kill_at));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge ck);
      #2;
    end
  endtask

  task automatic begin_frame();
    frame_base = disp_cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int i;
    i = 0;
    while (busy && i < budget) begin
      tick();
      i++;
    end
    check(tag, busy, 0);
    tick(2);
  endtask

  // Dispatched c values follow the raster walk; every write stores its own address.
  task automatic check_frame(input string tag, input int d0, input int w0,
                             input int nd, input int nw, input int chk_core);
    int mask;
    check({tag, "_dispatches"}, disp_cnt - d0, nd);
    check({tag, "_writes"}, wr_cnt - w0, nw);
    for (int i = 0; i < nd && (d0 + i) < disp_cnt; i++) begin
      check({tag, "_cre"}, d_cre[d0+i], -100 + (i % HRES) * 10);
      check({tag, "_cim"}, d_cim[d0+i], 50 - (i / HRES) * 10);
      if (chk_core != 0) check({tag, "_core"}, d_core[d0+i], i % NCORE);
    end
    mask = 0;
    for (int i = w0; i < wr_cnt; i++) begin
      check({tag, "_data_eq_addr"}, w_data[i], w_addr[i]);
      mask = mask | (1 << w_addr[i]);
    end
    check({tag, "_addr_set"}, mask, (1 << nw) - 1);
  endtask

  initial begin
    int d0, w0, dn0, i;
    rst = 1'b0; en_q = 1'b0; start = 1'b0;
    re0 = -16'sd100; im0 = 16'sd50; stp = 16'sd10;

    // Reset held three cycles
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_job_valid", job_valid, 0);
    check("rst_res_ready", res_ready, 0);
    check("rst_fb_we", fb_we, 0);
    check("rst_fb_addr", fb_addr, 0);
    check("rst_fb_data", fb_data, 0);
    check("rst_job_cre", job_cre, 0);
    check("rst_job_cim", job_cim, 0);
    rst = 1'b1;
    en_q = 1'b1;
    tick();

    // Full frame, engines always ready
    d0 = disp_cnt; w0 = wr_cnt; dn0 = done_cnt;
    begin_frame();
    wait_idle("full_idle", 200);
    check_frame("full", d0, w0, 8, 8, 1);
    check("full_done", done_cnt - dn0, 1);

    // Result contention: both engines finish, results released together
    d0 = disp_cnt; w0 = wr_cnt; dn0 = done_cnt;
    hold_res = 1'b1;
    begin_frame();
    i = 0;
    while (!(eng_busy[0] != 0 && eng_busy[1] != 0 && eng_cnt[0] == 0 && eng_cnt[1] == 0) && i < 50) begin
      tick();
      i++;
    end
    check("cont_both_ready", i < 50, 1);
    hold_res = 1'b0;
    tick();
    check("cont_res_ready", res_ready, 2'b01);
    wait_idle("cont_idle", 200);
    check_frame("cont", d0, w0, 8, 8, 0);
    check("cont_first_addr", w_addr[w0], 0);
    check("cont_second_addr", w_addr[w0+1], 1);
    check("cont_consecutive", w_cyc[w0+1] - w_cyc[w0], 1);
    check("cont_done", done_cnt - dn0, 1);

    // Back-pressure: job_ready held low for 5 cycles after the third job
    d0 = disp_cnt; w0 = wr_cnt; dn0 = done_cnt;
    bp_arm = 1;
    begin_frame();
    wait_idle("bp_idle", 300);
    check("bp_triggered", bp_arm, 0);
    check_frame("bp", d0, w0, 8, 8, 0);
    check("bp_done", done_cnt - dn0, 1);

    // Abort: enable drops together with the third job
    d0 = disp_cnt; w0 = wr_cnt; dn0 = done_cnt;
    kill_at = 3;
    begin_frame();
    wait_idle("abort_idle", 200);
    check_frame("abort", d0, w0, 3, 3, 0);
    check("abort_no_done", done_cnt - dn0, 0);
    kill_at = 0;
    tick();

    // Mid-frame reset, then a start with enable low
    dn0 = done_cnt;
    begin_frame();
    i = 0;
    while ((disp_cnt - frame_base) < 2 && i < 50) begin
      tick();
      i++;
    end
    check("mrst_reached_dispatch", i < 50, 1);
    rst = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
    check("mrst_busy", busy, 0);
    check("mrst_job_valid", job_valid, 0);
    check("mrst_res_ready", res_ready, 0);
    check("mrst_fb_we", fb_we, 0);
    check("mrst_job_cre", job_cre, 0);
    en_q = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(3);
    check("ign_busy", busy, 0);
    check("ign_job_valid", job_valid, 0);
    check("ign_no_done", done_cnt - dn0, 0);

    check("onehot_violations", oh_bad, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
